// File: rtl/conv_pe_array_pkg.sv
// Shared types and helpers for the convolution PE array.
// Holds the engine state enum and the output scale/saturate function.
package conv_pe_array_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    FLUSH   = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Counter width that never collapses to zero bits.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Arithmetic right shift, then clamp to a signed field of `width` bits.
  function automatic logic signed [63:0] sat_scale(
    input logic signed [63:0] acc,
    input int                 shift,
    input int                 width
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = acc >>> shift;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/conv_out_buffer.sv
// Output buffer: captures NB_PE accumulators with their tags and
// serialises them one lane per accepted handshake.
module conv_out_buffer
  import conv_pe_array_pkg::*;
#(
  parameter int DW    = 16,
  parameter int AW    = 32,
  parameter int NB_PE = 4,
  parameter int SCALE = 0,
  parameter int XW    = 7,
  parameter int YW    = 7,
  parameter int GW    = 2,
  parameter int CHW   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [NB_PE-1:0][AW-1:0]  acc,
  input  logic [XW-1:0]             tx,
  input  logic [YW-1:0]             ty,
  input  logic [GW-1:0]             tg,
  output logic                      empty,
  output logic [DW-1:0]             out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XW-1:0]             out_x,
  output logic [YW-1:0]             out_y,
  output logic [CHW-1:0]            out_ch
);

  localparam int LW = cw(NB_PE);

  logic [NB_PE-1:0][AW-1:0] data_q;
  logic [LW-1:0]            lane;
  logic                     valid;
  logic [XW-1:0]            tx_q;
  logic [YW-1:0]            ty_q;
  logic [GW-1:0]            tg_q;

  // Load a full group, then step through lanes on each handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      lane   <= '0;
      valid  <= 1'b0;
      tx_q   <= '0;
      ty_q   <= '0;
      tg_q   <= '0;
    end else if (load) begin
      data_q <= acc;
      lane   <= '0;
      valid  <= 1'b1;
      tx_q   <= tx;
      ty_q   <= ty;
      tg_q   <= tg;
    end else if (valid && out_ready) begin
      if (int'(lane) == NB_PE - 1) begin
        valid <= 1'b0;
        lane  <= '0;
      end else begin
        lane <= lane + 1'b1;
      end
    end
  end

  // Present the current lane, zeroed whenever nothing is buffered.
  always_comb begin
    empty     = !valid;
    out_valid = valid;
    out_data  = '0;
    out_x     = '0;
    out_y     = '0;
    out_ch    = '0;
    if (valid) begin
      out_data = DW'(sat_scale(64'($signed(data_q[lane])), SCALE, DW));
      out_x    = tx_q;
      out_y    = ty_q;
      out_ch   = CHW'(int'(tg_q) * NB_PE + int'(lane));
    end
  end

endmodule

// File: rtl/conv_pe_array.sv
// Convolution engine: NB_PE output channels per group, one tap per
// cycle, with the next group computing while the previous one drains.
module conv_pe_array
  import conv_pe_array_pkg::*;
#(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int INPUT_NB_CHANNELS  = 2,
  parameter int OUTPUT_NB_CHANNELS = 16,
  parameter int KERNEL_SIZE        = 3,
  parameter int NB_PE              = 4,
  parameter int OUTPUT_SCALE       = 0
) (
  input  logic clk,
  input  logic arst_n_in,
  input  logic start,
  output logic running,
  output logic done,
  output logic in_mem_re,
  output logic [$clog2(INPUT_NB_CHANNELS*FEATURE_MAP_HEIGHT*FEATURE_MAP_WIDTH)-1:0] in_mem_addr,
  input  logic [IO_DATA_WIDTH-1:0] in_mem_qout,
  output logic k_mem_re,
  output logic [$clog2(INPUT_NB_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*OUTPUT_NB_CHANNELS/NB_PE)-1:0] k_mem_addr,
  input  logic [NB_PE*IO_DATA_WIDTH-1:0] k_mem_qout,
  output logic [IO_DATA_WIDTH-1:0] out_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0] out_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] out_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] out_ch
);

  localparam int DW  = IO_DATA_WIDTH;
  localparam int ACW = ACCUMULATION_WIDTH;
  localparam int W   = FEATURE_MAP_WIDTH;
  localparam int H   = FEATURE_MAP_HEIGHT;
  localparam int IC  = INPUT_NB_CHANNELS;
  localparam int K   = KERNEL_SIZE;
  localparam int NG  = OUTPUT_NB_CHANNELS / NB_PE;
  localparam int IAW = $clog2(IC * H * W);
  localparam int KAW = $clog2(IC * K * K * NG);
  localparam int ICW = cw(IC);
  localparam int KW  = cw(K);
  localparam int XW  = $clog2(W);
  localparam int YW  = $clog2(H);
  localparam int GW  = cw(NG);
  localparam int CHW = $clog2(OUTPUT_NB_CHANNELS);

  state_t state;
  state_t nstate;

  logic [ICW-1:0] inch;
  logic [KW-1:0]  ky;
  logic [KW-1:0]  kx;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [GW-1:0]  g;
  logic [XW-1:0]  tx;
  logic [YW-1:0]  ty;
  logic [GW-1:0]  tg;

  logic fin;
  logic pend;
  logic v_q;
  logic first_q;
  logic pad_q;

  logic issue;
  logic pad;
  logic tap_first;
  logic tap_last;
  logic grp_final;
  logic empty;
  logic load;
  int   yy;
  int   xx;

  logic [DW-1:0]               act;
  logic signed [2*DW-1:0]      prod [NB_PE];
  logic [NB_PE-1:0][ACW-1:0]   acc;
  logic [NB_PE-1:0][ACW-1:0]   acc_next;

  // Tap position flags within the current group and layer.
  always_comb begin
    tap_first = (inch == '0) && (ky == '0) && (kx == '0);
    tap_last  = (int'(inch) == IC - 1) && (int'(ky) == K - 1)
             && (int'(kx) == K - 1);
    grp_final = (int'(x) == W - 1) && (int'(y) == H - 1)
             && (int'(g) == NG - 1);
  end

  // Signed window coordinates, padding test and memory requests.
  always_comb begin
    yy          = int'(y) + int'(ky) - K / 2;
    xx          = int'(x) + int'(kx) - K / 2;
    pad         = (yy < 0) || (yy >= H) || (xx < 0) || (xx >= W);
    issue       = (state == COMPUTE);
    in_mem_re   = issue && !pad;
    k_mem_re    = issue;
    in_mem_addr = '0;
    k_mem_addr  = '0;
    if (in_mem_re)
      in_mem_addr = IAW'((int'(inch) * H + yy) * W + xx);
    if (issue)
      k_mem_addr = KAW'(((int'(inch) * K + int'(ky)) * K + int'(kx))
                 * NG + int'(g));
  end

  // Multiply returning data; the first tap of a group restarts the sum.
  always_comb begin
    act = pad_q ? '0 : in_mem_qout;
    for (int p = 0; p < NB_PE; p++) begin
      prod[p] = $signed(act) * $signed(k_mem_qout[p*DW +: DW]);
      acc_next[p] = acc[p];
      if (v_q)
        acc_next[p] = first_q ? ACW'(prod[p])
                              : acc[p] + ACW'(prod[p]);
    end
  end

  // Copy the finished group once the buffer has drained.
  always_comb begin
    load = ((state == FLUSH) || (state == HOLD && pend)) && empty;
  end

  // State register.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) state <= IDLE;
    else            state <= nstate;
  end

  // Next-state logic.
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start) nstate = COMPUTE;
      COMPUTE: if (tap_last) nstate = FLUSH;
      FLUSH:   if (empty && !fin) nstate = COMPUTE;
               else nstate = HOLD;
      HOLD:    if (empty) begin
                 if (!pend)     nstate = IDLE;
                 else if (!fin) nstate = COMPUTE;
               end
      default: nstate = IDLE;
    endcase
  end

  // Status outputs.
  always_comb begin
    running = (state != IDLE);
    done    = (state == HOLD) && empty && !pend;
  end

  // Tap and position counters, plus tags of the group just issued.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      inch <= '0;
      ky   <= '0;
      kx   <= '0;
      x    <= '0;
      y    <= '0;
      g    <= '0;
      tx   <= '0;
      ty   <= '0;
      tg   <= '0;
      fin  <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        inch <= '0;
        ky   <= '0;
        kx   <= '0;
        x    <= '0;
        y    <= '0;
        g    <= '0;
        fin  <= 1'b0;
      end
    end else if (issue) begin
      if (tap_last) begin
        inch <= '0;
        ky   <= '0;
        kx   <= '0;
        tx   <= x;
        ty   <= y;
        tg   <= g;
        fin  <= grp_final;
        if (int'(g) == NG - 1) begin
          g <= '0;
          if (int'(x) == W - 1) begin
            x <= '0;
            if (int'(y) == H - 1) y <= '0;
            else                  y <= y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
        end else begin
          g <= g + 1'b1;
        end
      end else if (int'(kx) == K - 1) begin
        kx <= '0;
        if (int'(ky) == K - 1) begin
          ky   <= '0;
          inch <= inch + 1'b1;
        end else begin
          ky <= ky + 1'b1;
        end
      end else begin
        kx <= kx + 1'b1;
      end
    end
  end

  // Read-latency pipeline and accumulators.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      v_q     <= 1'b0;
      first_q <= 1'b0;
      pad_q   <= 1'b0;
      acc     <= '0;
    end else begin
      v_q     <= issue;
      first_q <= issue && tap_first;
      pad_q   <= issue && pad;
      acc     <= acc_next;
    end
  end

  // Remember a finished group still waiting for buffer space.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in)          pend <= 1'b0;
    else if (load)           pend <= 1'b0;
    else if (state == FLUSH) pend <= 1'b1;
  end

  conv_out_buffer #(
    .DW    (DW),
    .AW    (ACW),
    .NB_PE (NB_PE),
    .SCALE (OUTPUT_SCALE),
    .XW    (XW),
    .YW    (YW),
    .GW    (GW),
    .CHW   (CHW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (arst_n_in),
    .load      (load),
    .acc       (acc_next),
    .tx        (tx),
    .ty        (ty),
    .tg        (tg),
    .empty     (empty),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_ch    (out_ch)
  );

endmodule

// File: tb/tb_conv_pe_array.sv
// Bench for conv_pe_array: two instances (scale 0 and scale 2) on the
// same stimulus, checked against a direct convolution model.
module tb_conv_pe_array;
  import conv_pe_array_pkg::*;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int OC = 4;
  localparam int NP = 2;
  localparam int K  = 3;
  localparam int NG = OC / NP;
  localparam int T  = K * K;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic ready;
  always #5 clk = ~clk;

  logic        run_a, done_a, ire_a, kre_a, ov_a;
  logic [3:0]  ia_a;
  logic [4:0]  ka_a;
  logic [15:0] iq_a, od_a;
  logic [31:0] kq_a;
  logic [1:0]  ox_a, oy_a, oc_a;

  logic        run_b, done_b, ire_b, kre_b, ov_b;
  logic [3:0]  ia_b;
  logic [4:0]  ka_b;
  logic [15:0] iq_b, od_b;
  logic [31:0] kq_b;
  logic [1:0]  ox_b, oy_b, oc_b;

  conv_pe_array #(
    .IO_DATA_WIDTH(16), .ACCUMULATION_WIDTH(32),
    .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H),
    .INPUT_NB_CHANNELS(1), .OUTPUT_NB_CHANNELS(OC),
    .KERNEL_SIZE(K), .NB_PE(NP), .OUTPUT_SCALE(0)
  ) dut_a (
    .clk(clk), .arst_n_in(rst_n), .start(start),
    .running(run_a), .done(done_a),
    .in_mem_re(ire_a), .in_mem_addr(ia_a), .in_mem_qout(iq_a),
    .k_mem_re(kre_a), .k_mem_addr(ka_a), .k_mem_qout(kq_a),
    .out_data(od_a), .out_valid(ov_a), .out_ready(ready),
    .out_x(ox_a), .out_y(oy_a), .out_ch(oc_a)
  );

  conv_pe_array #(
    .IO_DATA_WIDTH(16), .ACCUMULATION_WIDTH(32),
    .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H),
    .INPUT_NB_CHANNELS(1), .OUTPUT_NB_CHANNELS(OC),
    .KERNEL_SIZE(K), .NB_PE(NP), .OUTPUT_SCALE(2)
  ) dut_b (
    .clk(clk), .arst_n_in(rst_n), .start(start),
    .running(run_b), .done(done_b),
    .in_mem_re(ire_b), .in_mem_addr(ia_b), .in_mem_qout(iq_b),
    .k_mem_re(kre_b), .k_mem_addr(ka_b), .k_mem_qout(kq_b),
    .out_data(od_b), .out_valid(ov_b), .out_ready(ready),
    .out_x(ox_b), .out_y(oy_b), .out_ch(oc_b)
  );

  logic signed [15:0] act_m [H*W];
  logic signed [15:0] wk [OC][K][K];
  logic [15:0] got_a [H][W][OC];
  logic [15:0] got_b [H][W][OC];
  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] kword(input logic [4:0] a);
    int tap, gg;
    logic [31:0] r;
    tap = int'(a) / NG;
    gg  = int'(a) % NG;
    r = '0;
    if (tap < T)
      for (int p = 0; p < NP; p++)
        r[p*16 +: 16] = wk[gg*NP+p][tap/K][tap%K];
    return r;
  endfunction

  always @(posedge clk) begin
    if (ire_a) iq_a <= act_m[ia_a];
    if (kre_a) kq_a <= kword(ka_a);
    if (ire_b) iq_b <= act_m[ia_b];
    if (kre_b) kq_b <= kword(ka_b);
  end

  // Direct zero-padded convolution, 32-bit wrap, shift, clamp.
  function automatic logic [15:0] ref_out(input int y, input int x,
                                          input int c, input int sc);
    int acc, s, yy, xx;
    acc = 0;
    for (int ky = 0; ky < K; ky++)
      for (int kx = 0; kx < K; kx++) begin
        yy = y + ky - 1;
        xx = x + kx - 1;
        if (yy >= 0 && yy < H && xx >= 0 && xx < W)
          acc += int'(act_m[yy*W+xx]) * int'(wk[c][ky][kx]);
      end
    s = acc >>> sc;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_a"}, {run_a, done_a, ire_a, kre_a, ov_a, ia_a, ka_a,
                      od_a, ox_a, oy_a, oc_a}, '0);
    chk({tag, "_b"}, {run_b, done_b, ire_b, kre_b, ov_b, ia_b, ka_b,
                      od_b, ox_b, oy_b, oc_b}, '0);
  endtask

  // 0 ones, 1 single 0x7FFF with 0x7FFF weights, 2 same with 0x8001,
  // 3 all twos, 4 random full range.
  task automatic fill(input int mode);
    for (int i = 0; i < H*W; i++) begin
      case (mode)
        0: act_m[i] = 16'sd1;
        1, 2: act_m[i] = (i == 1*W+1) ? 16'sh7FFF : 16'sd0;
        3: act_m[i] = 16'sd2;
        default: act_m[i] = 16'($urandom());
      endcase
    end
    for (int c = 0; c < OC; c++)
      for (int a = 0; a < K; a++)
        for (int b = 0; b < K; b++)
          case (mode)
            0: wk[c][a][b] = 16'sd1;
            1: wk[c][a][b] = 16'sh7FFF;
            2: wk[c][a][b] = 16'sh8001;
            3: wk[c][a][b] = 16'sd2;
            default: wk[c][a][b] = 16'($urandom());
          endcase
  endtask

  task automatic run_layer(input int stall, input bit poke);
    int n, nd, sleft, first, ey, ex, ec;
    bit seen;
    logic [15:0] sd;
    logic [1:0] sx, sy, sc;
    n = 0; nd = 0; sleft = 0; first = -1; seen = 0;
    sd = '0; sx = '0; sy = '0; sc = '0;
    ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 800 && nd == 0; cyc++) begin
      start = poke && (cyc == 20);
      if (ov_a && !seen) begin
        seen = 1; first = cyc; sleft = stall;
        sd = od_a; sx = ox_a; sy = oy_a; sc = oc_a;
      end
      if (sleft > 0) begin
        ready = 1'b0;
        if (cyc > first) begin
          chk("stall_data", od_a, sd);
          chk("stall_tags", {ox_a, oy_a, oc_a}, {sx, sy, sc});
          chk("stall_valid", ov_a, 1'b1);
        end
        if (sleft == 1) begin
          chk("hold_state", dut_a.state, HOLD);
          chk("hold_re", {ire_a, kre_a}, 2'b00);
        end
        sleft--;
      end else begin
        ready = 1'b1;
      end
      if (ov_a && ready) begin
        if (n < H*W*OC) begin
          ey = n / (W*OC); ex = (n / OC) % W; ec = n % OC;
          chk($sformatf("tag_x n=%0d", n), ox_a, ex);
          chk($sformatf("tag_y n=%0d", n), oy_a, ey);
          chk($sformatf("tag_ch n=%0d", n), oc_a, ec);
          chk($sformatf("data_s0 n=%0d", n), od_a, ref_out(ey, ex, ec, 0));
          chk($sformatf("data_s2 n=%0d", n), od_b, ref_out(ey, ex, ec, 2));
          got_a[ey][ex][ec] = od_a;
          got_b[ey][ex][ec] = od_b;
        end
        n++;
      end
      if (done_a) nd++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("latency", first, T + 1);
    chk("count", n, H*W*OC);
    chk("done_pulses", nd, 1);
    chk("idle_after", {done_a, run_a, ov_a}, 3'b000);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ready = 1'b1;
    fill(0);
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk_idle("idle10");

    fill(0);
    run_layer(0, 0);
    for (int c = 0; c < OC; c++) begin
      chk("pad_corner", got_a[0][0][c], 16'd4);
      chk("pad_center", got_a[1][1][c], 16'd9);
      chk("pad_edge", got_a[1][3][c], 16'd6);
    end

    fill(1);
    run_layer(0, 0);
    chk("sat_pos", got_a[1][1][0], 16'h7FFF);

    fill(2);
    run_layer(0, 0);
    chk("sat_neg", got_a[1][1][1], 16'h8000);

    fill(3);
    run_layer(0, 0);
    chk("scale2", got_b[1][1][0], 16'd9);

    fill(0);
    run_layer(20, 0);
    chk("bp_center", got_a[1][1][3], 16'd9);

    fill(4);
    run_layer(0, 1);

    fill(4);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_idle("abort");
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_idle("post_abort");
    fill(4);
    run_layer(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
